// File: rtl/prog_loader_if.sv
// Byte-stream input and RAM write port of the program loader.
interface prog_loader_if #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;

    // Host / stream source side
    modport master (
        output in_valid, in_data,
        input  in_ready, ram_we, ram_addr, ram_wdata
    );

    // Loader side
    modport slave (
        input  in_valid, in_data,
        output in_ready, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Loads a length-prefixed byte stream into RAM from address 0, zero-fills the
// remaining words, then releases the CPU core from hold after a settle delay.
module prog_loader #(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_req,
    prog_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          err
);
    localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
    localparam int unsigned LEN_W  = DATA_WIDTH + 1;
    localparam int unsigned HOLD_W = 8;

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_CLEAR,
        S_HOLD,
        S_RUN,
        S_ERROR
    } state_t;

    state_t                state_q,     state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q,    wr_ptr_d;
    logic [CNT_W-1:0]      remaining_q, remaining_d;
    logic                  len_full_q,  len_full_d;
    logic [HOLD_W-1:0]     hold_cnt_q,  hold_cnt_d;
    logic                  in_ready_q,  in_ready_d;
    logic                  ram_we_q,    ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic                  cpu_hold_q,  cpu_hold_d;
    logic                  done_q,      done_d;
    logic                  err_q,       err_d;

    logic             accept;
    logic [LEN_W-1:0] len_ext;

    assign accept  = bus.in_valid && in_ready_q;
    assign len_ext = LEN_W'(bus.in_data);

    // State register and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_LEN;
            wr_ptr_q    <= '0;
            remaining_q <= '0;
            len_full_q  <= 1'b0;
            hold_cnt_q  <= '0;
            in_ready_q  <= 1'b1;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            remaining_q <= remaining_d;
            len_full_q  <= len_full_d;
            hold_cnt_q  <= hold_cnt_d;
            in_ready_q  <= in_ready_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next-state, counters and next output values
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        remaining_d = remaining_q;
        len_full_d  = len_full_q;
        hold_cnt_d  = '0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;

        if (load_req) begin
            // A reload wins over any byte presented in the same cycle
            state_d     = S_LEN;
            wr_ptr_d    = '0;
            remaining_d = '0;
            len_full_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_LEN: begin
                    if (accept) begin
                        if ((len_ext != '0) && (len_ext <= LEN_W'(DEPTH))) begin
                            state_d     = S_DATA;
                            wr_ptr_d    = '0;
                            remaining_d = CNT_W'(bus.in_data);
                            len_full_d  = (len_ext == LEN_W'(DEPTH));
                        end else begin
                            state_d = S_ERROR;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        ram_we_d    = 1'b1;
                        ram_addr_d  = wr_ptr_q;
                        ram_wdata_d = bus.in_data;
                        wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(1);
                        remaining_d = remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            state_d = len_full_q ? S_HOLD : S_CLEAR;
                        end
                    end
                end
                S_CLEAR: begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = wr_ptr_q;
                    ram_wdata_d = '0;
                    // Stop at the top address so the pointer never wraps to 0
                    if (wr_ptr_q == '1) begin
                        state_d = S_HOLD;
                    end else begin
                        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
                    end
                end
                S_HOLD: begin
                    // Count 0 is the cycle still showing the last write
                    if (hold_cnt_q == HOLD_W'(HOLD_CYCLES)) begin
                        state_d = S_RUN;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                S_RUN:   state_d = S_RUN;
                S_ERROR: state_d = S_ERROR;
                default: state_d = S_LEN;
            endcase
        end

        in_ready_d = (state_d == S_LEN) || (state_d == S_DATA);
        cpu_hold_d = (state_d != S_RUN);
        done_d     = (state_d == S_RUN);
        err_d      = (state_d == S_ERROR);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign cpu_hold      = cpu_hold_q;
    assign done          = done_q;
    assign err           = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: directed streams push expected RAM writes,
// a negedge monitor pops and compares every ram_we cycle.
module tb_prog_loader;
    localparam int unsigned AW   = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned HOLD = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic clk;
    logic reset;
    logic load_req;
    logic cpu_hold;
    logic done;
    logic err;

    int checks;
    int errors;
    int wr_count;
    wr_t exp_q[$];

    prog_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    prog_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HOLD_CYCLES(HOLD)) dut (
        .clk      (clk),
        .reset    (reset),
        .load_req (load_req),
        .bus      (bus.slave),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int a, input int d);
        wr_t e;
        e.a = AW'(a);
        e.d = DW'(d);
        exp_q.push_back(e);
    endtask

    task automatic push_clear(input int from);
        for (int a = from; a < (1 << AW); a++) push(a, 0);
    endtask

    // Present a byte and return just after the edge that accepted it
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck at %0b want 1", bus.in_ready);
        end
        tick();
    endtask

    task automatic stop();
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    // Wait for release; check the hold gap after the final write and RUN outputs
    task automatic wait_run(input string name);
        int last_we;
        int low_at;
        last_we = -1;
        low_at  = -1;
        for (int i = 0; i < 300; i++) begin
            if (bus.ram_we) last_we = i;
            if (!cpu_hold) begin
                low_at = i;
                break;
            end
            tick();
        end
        if (low_at < 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: cpu_hold still %0b want 0", name, cpu_hold);
        end else begin
            check({name, "_hold_gap"}, 32'(low_at - last_we), 32'(HOLD + 1));
            check({name, "_done"}, 32'(done), 32'd1);
            check({name, "_in_ready"}, 32'(bus.in_ready), 32'd0);
            check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        end
    endtask

    // Monitor: every RAM write must match the head of the expected queue
    initial begin
        wr_t e;
        wr_count = 0;
        forever begin
            @(negedge clk);
            if (bus.ram_we) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h want no write",
                             bus.ram_addr, bus.ram_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(bus.ram_addr), 32'(e.a));
                    check("wr_data", 32'(bus.ram_wdata), 32'(e.d));
                end
            end
        end
    end

    initial begin
        int base;
        checks       = 0;
        errors       = 0;
        reset        = 1'b0;
        load_req     = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Reset values
        #12;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_ram_we", 32'(bus.ram_we), 32'd0);
        check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        check("rst_ram_wdata", 32'(bus.ram_wdata), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();

        // Short program, zero-fill of 2..15
        base = wr_count;
        push(0, 8'h2E);
        push(1, 8'hFF);
        push_clear(2);
        send(8'h02);
        send(8'h2E);
        send(8'hFF);
        stop();
        check("t1_in_ready_drop", 32'(bus.in_ready), 32'd0);
        wait_run("t1");
        check("t1_writes", 32'(wr_count - base), 32'd16);

        // Full-depth program, back-to-back bytes, no clear phase
        pulse_load();
        check("t2_reload_hold", 32'(cpu_hold), 32'd1);
        check("t2_reload_done", 32'(done), 32'd0);
        check("t2_reload_ready", 32'(bus.in_ready), 32'd1);
        base = wr_count;
        for (int i = 0; i < 16; i++) push(i, i);
        send(8'h10);
        for (int i = 0; i < 16; i++) send(8'(i));
        stop();
        wait_run("t2");
        check("t2_writes", 32'(wr_count - base), 32'd16);

        // Illegal lengths
        pulse_load();
        send(8'h00);
        check("t3_err_zero", 32'(err), 32'd1);
        check("t3_ready_zero", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h42;
        repeat (3) tick();
        stop();
        check("t3_err_sticky", 32'(err), 32'd1);
        pulse_load();
        check("t3_err_clear", 32'(err), 32'd0);
        check("t3_ready_back", 32'(bus.in_ready), 32'd1);
        send(8'h11);
        stop();
        check("t3_err_big", 32'(err), 32'd1);
        check("t3_hold_big", 32'(cpu_hold), 32'd1);
        pulse_load();
        check("t3_err_clear2", 32'(err), 32'd0);
        push(0, 8'h7E);
        push_clear(1);
        send(8'h01);
        send(8'h7E);
        stop();
        wait_run("t3");

        // Toggling valid, abort before the third byte with a colliding byte
        pulse_load();
        base = wr_count;
        send(8'h03);
        stop();
        tick();
        check("t4_hold_a", 32'(cpu_hold), 32'd1);
        push(0, 8'hAA);
        send(8'hAA);
        stop();
        tick();
        check("t4_hold_b", 32'(cpu_hold), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hBB;
        load_req     = 1'b1;
        tick();
        load_req = 1'b0;
        stop();
        check("t4_ready_len", 32'(bus.in_ready), 32'd1);
        check("t4_hold_c", 32'(cpu_hold), 32'd1);
        check("t4_no_collide_we", 32'(bus.ram_we), 32'd0);
        repeat (3) tick();
        check("t4_writes", 32'(wr_count - base), 32'd1);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);
        // Still in LEN: a fresh load completes
        push(0, 8'h11);
        push(1, 8'h22);
        push_clear(2);
        send(8'h02);
        send(8'h11);
        send(8'h22);
        stop();
        wait_run("t4");

        // Stream ignored while running, then reload
        base = wr_count;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_done", 32'(done), 32'd1);
        end
        stop();
        check("t5_writes", 32'(wr_count - base), 32'd0);
        pulse_load();
        check("t5_reload_hold", 32'(cpu_hold), 32'd1);
        check("t5_reload_done", 32'(done), 32'd0);

        // Async reset mid-DATA after 2 of 5 bytes
        push(0, 8'h01);
        push(1, 8'h02);
        send(8'h05);
        send(8'h01);
        send(8'h02);
        stop();
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("t6_ready", 32'(bus.in_ready), 32'd1);
        check("t6_hold", 32'(cpu_hold), 32'd1);
        check("t6_done", 32'(done), 32'd0);
        check("t6_err", 32'(err), 32'd0);
        check("t6_we", 32'(bus.ram_we), 32'd0);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        push(0, 8'h0A);
        push(1, 8'h0B);
        push(2, 8'h0C);
        push_clear(3);
        send(8'h03);
        send(8'h0A);
        send(8'h0B);
        send(8'h0C);
        stop();
        wait_run("t6");

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader sitting directly upstream of the SAP-1.5 RAM and CPU core.
- Receives a length-prefixed program over a valid/ready byte interface and writes it into RAM from address 0.
- Zero-fills the unused addresses, then releases the CPU from hold so it runs the program.
- Replaces bench-side RAM preloading on hardware. A host or UART receiver drives the stream.

Parameters:
- ADDR_WIDTH, 4, RAM address width; RAM depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, RAM word and stream byte width.
- HOLD_CYCLES, 4, cycles cpu_hold stays high after the last RAM write, before release (1..255).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (one clock; reset asserted low clears all state immediately).
- in_valid  input  1  stream byte valid.
- in_data  input  DATA_WIDTH  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- load_req  input  1  single-cycle request to (re)load; aborts any load in progress.
- ram_we  output  1  RAM write strobe, one cycle per word.
- ram_addr  output  ADDR_WIDTH  RAM write address.
- ram_wdata  output  DATA_WIDTH  RAM write data.
- cpu_hold  output  1  high = CPU core held in reset; integrator maps this to the core reset.
- done  output  1  high while CPU is released and running the loaded program.
- err  output  1  high after an illegal length byte, until reload or reset.

Behaviour:
- Reset values: state=LEN, in_ready=1, ram_we=0, ram_addr=0, ram_wdata=0, cpu_hold=1, done=0, err=0, internal counters=0.
- A byte transfers on a rising edge where in_valid && in_ready. in_data is ignored otherwise. in_ready is a registered state decode and does not depend on in_valid.
- States: LEN, DATA, CLEAR, HOLD, RUN, ERROR.
- LEN:
  - in_ready=1.
  - Accepted byte is len. Legal range is 1..2**ADDR_WIDTH; legal -> DATA, wr_ptr=0, remaining=len.
  - len==0 or len>2**ADDR_WIDTH -> ERROR, err=1.
- DATA:
  - in_ready=1.
  - Accepted byte B: the next cycle ram_we=1, ram_addr=wr_ptr, ram_wdata=B; wr_ptr increments, remaining decrements.
  - Write latency is exactly 1 cycle after acceptance. Back-to-back bytes give back-to-back writes.
  - On the last byte (remaining==1): if len==2**ADDR_WIDTH -> HOLD, else -> CLEAR.
  - in_ready drops the cycle after the last byte is accepted.
- CLEAR:
  - in_ready=0.
  - Writes 0x00 to addresses len..2**ADDR_WIDTH-1, one per cycle with ram_we=1.
  - After the top address is written -> HOLD. wr_ptr must not wrap into address 0.
- HOLD: in_ready=0, ram_we=0, cpu_hold=1. Count HOLD_CYCLES cycles, then -> RUN.
- RUN: cpu_hold=0, done=1, in_ready=0. Stream input is ignored.
- ERROR: cpu_hold=1, err=1, in_ready=0, no RAM writes.
- load_req, from any state:
  - Next state is LEN; wr_ptr and remaining are cleared; err=0, done=0, cpu_hold=1 on the next edge.
  - No ram_we is issued for a byte accepted in the same cycle as load_req. load_req wins.
- ram_we is never high outside DATA/CLEAR write cycles. ram_addr/ram_wdata hold their last values when ram_we=0.
- Async reset low mid-load: all outputs return to reset values immediately. RAM contents are not touched. CPU stays held until a full new load completes.
- cpu_hold rises no later than the edge after load_req. It never glitches low between load_req and RUN.

Test Plan:
- Reset, stream 0x02,0x2E,0xFF -> writes (0,0x2E),(1,0xFF), then addresses 2..15 each written 0x00, HOLD 4 cycles, cpu_hold falls, done=1. Core then executes LDB from ram[14]=0x00 and halts, B=0x00.
- Stream len=0x10 plus 16 bytes 0x00..0x0F with in_valid held high -> 16 consecutive ram_we cycles, addresses 0..15, data = address, no CLEAR writes, done after HOLD.
- Stream 0x00, then separately 0x11 -> err=1, in_ready=0, no ram_we; load_req -> err=0, in_ready=1, and a subsequent valid load completes.
- Stream 0x03,0xAA with in_valid toggling every other cycle, then load_req before the third byte -> only (0,0xAA) written, state LEN, cpu_hold=1 throughout.
- In RUN, assert in_valid with 0x55 for 5 cycles -> no ram_we, done stays 1; load_req -> cpu_hold=1 and done=0 next edge.
- Drop reset low during DATA after 2 of 5 bytes -> in_ready=1, cpu_hold=1, done=0, err=0 immediately; a fresh load then succeeds.
